// File: rtl/matrix_deserializer_if.sv
// Element stream in, flat N*N matrix out, plus the framing-error pulse.
// slave is the deserializer's view; master is the producer/consumer view.
interface matrix_deserializer_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  logic                   s_valid;
  logic                   s_ready;
  logic [WIDTH-1:0]       s_data;
  logic                   s_last;
  logic                   m_valid;
  logic                   m_ready;
  logic [N*N*WIDTH-1:0]   m_data;
  logic                   err_len;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, err_len
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, err_len
  );
endinterface

// File: rtl/matrix_deserializer.sv
// Row-major element stream into ping-pong N*N matrix banks; matrix valid the cycle after its last element.
// Backpressure: s_ready is a register that drops once both banks hold completed matrices.
module matrix_deserializer #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  matrix_deserializer_if.slave  io
);
  localparam int NN = N * N;
  localparam int KW = (NN > 1) ? $clog2(NN) : 1;
  localparam int MW = NN * WIDTH;

  logic [KW-1:0]  k_q, k_d;
  logic [1:0]     occ_q, occ_d;
  logic           wr_bank_q, wr_bank_d;
  logic           rd_bank_q, rd_bank_d;
  logic           err_q, err_d;
  logic           rdy_q, rdy_d;
  logic [MW-1:0]  bank_q [2];

  logic           s_fire;
  logic           m_fire;
  logic           last_idx;
  logic           frame_done;

  always_comb begin
    s_fire     = io.s_valid && rdy_q;
    m_fire     = io.m_ready && (occ_q != 2'd0);
    last_idx   = (k_q == KW'(NN - 1));
    frame_done = s_fire && last_idx;

    k_d       = k_q;
    occ_d     = occ_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;

    if (s_fire) begin
      k_d = last_idx ? '0 : k_q + KW'(1);
    end
    if (frame_done) begin
      wr_bank_d = ~wr_bank_q;
    end
    if (m_fire) begin
      rd_bank_d = ~rd_bank_q;
    end

    case ({frame_done, m_fire})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    // s_last only cross-checks the count; it never steers framing
    err_d = s_fire && (io.s_last != last_idx);
    rdy_d = (occ_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      k_q       <= '0;
      occ_q     <= 2'd0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      k_q       <= k_d;
      occ_q     <= occ_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      err_q     <= err_d;
      rdy_q     <= rdy_d;
    end
  end

  // Bank storage is never cleared; m_valid qualifies it
  always_ff @(posedge clk) begin
    if (rstn && s_fire) begin
      bank_q[wr_bank_q][int'(k_q) * WIDTH +: WIDTH] <= io.s_data;
    end
  end

  assign io.s_ready = rdy_q;
  assign io.m_valid = (occ_q != 2'd0);
  assign io.m_data  = bank_q[rd_bank_q];
  assign io.err_len = err_q;

endmodule

// File: tb/tb_matrix_deserializer.sv
// Randomized bench for matrix_deserializer with a queue-based reference model.
module tb_matrix_deserializer;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int NN = N * N;
  localparam int MW = NN * W;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  matrix_deserializer_if #(.N(N), .WIDTH(W)) bus ();
  matrix_deserializer #(.N(N), .WIDTH(W)) dut (.clk(clk), .rstn(rstn), .io(bus));

  int errors = 0;
  int checks = 0;

  task automatic check_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_byte(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_mat(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: accepted elements build a matrix; completed matrices wait in a FIFO of depth 2
  logic [MW-1:0] exp_q[$];
  logic [MW-1:0] cur;
  logic [MW-1:0] prev_data;
  int  cnt = 0;
  bit  exp_err = 1'b0;
  bit  in_rst = 1'b1;
  bit  chk_en = 1'b0;
  bit  prev_hold = 1'b0;
  int  cyc = 0;
  int  hs_cnt = 0;
  int  err_pulses = 0;
  int  rdy_low = 0;
  int  hs_cyc[$];
  int  mr_mode = 1;

  always @(negedge clk) begin
    bit sf;
    bit mf;
    cyc++;
    if (chk_en) begin
      check_bit("m_valid", bus.m_valid, exp_q.size() != 0);
      check_bit("s_ready", bus.s_ready, !in_rst && exp_q.size() < 2);
      check_bit("err_len", bus.err_len, exp_err);
      if (exp_q.size() != 0) check_mat("m_data", bus.m_data, exp_q[0]);
      if (prev_hold) check_mat("m_data_hold", bus.m_data, prev_data);
      if (bus.err_len === 1'b1) err_pulses++;
      if (bus.s_ready !== 1'b1) rdy_low++;
    end
    prev_hold = (exp_q.size() != 0) && (bus.m_ready !== 1'b1);
    prev_data = bus.m_data;
    if (!rstn) begin
      exp_q.delete();
      cnt = 0;
      exp_err = 1'b0;
      in_rst = 1'b1;
      prev_hold = 1'b0;
    end else begin
      sf = (bus.s_valid === 1'b1) && !in_rst && exp_q.size() < 2;
      mf = (bus.m_ready === 1'b1) && exp_q.size() != 0;
      in_rst = 1'b0;
      exp_err = sf && (bus.s_last != (cnt == NN - 1));
      if (mf) begin
        void'(exp_q.pop_front());
        hs_cnt++;
        hs_cyc.push_back(cyc);
      end
      if (sf) begin
        cur[cnt*W +: W] = bus.s_data;
        cnt++;
        if (cnt == NN) begin
          exp_q.push_back(cur);
          cnt = 0;
        end
      end
    end
    chk_en = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    case (mr_mode)
      0:       bus.m_ready = 1'b0;
      1:       bus.m_ready = 1'b1;
      default: bus.m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send(input logic [7:0] d, input bit last, input bit rnd_gap);
    bit ok;
    ok = 1'b0;
    if (rnd_gap) begin
      while ($urandom_range(0, 1) == 1) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      ok = (bus.s_ready === 1'b1);
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) check_bit("send_timeout", 1'b0, 1'b1);
    bus.s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [MW-1:0] m, input bit rnd_gap, input int last_k);
    for (int k = 0; k < NN; k++) send(m[k*W +: W], k == last_k, rnd_gap);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && cnt == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_bit("drain_timeout", 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] m;
    for (int k = 0; k < NN; k++) m[k*W +: W] = 8'($urandom_range(0, 255));
    return m;
  endfunction

  initial begin
    logic [MW-1:0] m;
    int h0;
    int e0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_m_valid", bus.m_valid, 1'b0);
    check_bit("rst_s_ready", bus.s_ready, 1'b0);
    check_bit("rst_err_len", bus.err_len, 1'b0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check_bit("rel_s_ready", bus.s_ready, 1'b1);

    // Single frame of 10*r+c
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[(r*N+c)*W +: W] = 8'(10*r + c);
    send_frame(m, 1'b0, NN - 1);
    check_bit("t1_m_valid", bus.m_valid, 1'b1);
    check_byte("t1_e00", bus.m_data[7:0], 8'd0);
    check_byte("t1_e01", bus.m_data[15:8], 8'd1);
    check_byte("t1_e10", bus.m_data[39:32], 8'd10);
    check_byte("t1_e33", bus.m_data[127:120], 8'd33);
    drain();
    check_int("t1_err_pulses", err_pulses, 0);

    // Back-to-back frames
    hs_cyc.delete();
    rdy_low = 0;
    for (int f = 0; f < 4; f++) send_frame(rand_mat(), 1'b0, NN - 1);
    drain();
    check_int("b2b_rdy_low", rdy_low, 0);
    check_int("b2b_hs", hs_cyc.size(), 4);
    for (int i = 1; i < hs_cyc.size(); i++) check_int("b2b_spacing", hs_cyc[i] - hs_cyc[i-1], NN);

    // Backpressure
    mr_mode = 0;
    h0 = hs_cnt;
    @(posedge clk); #1;
    send_frame(rand_mat(), 1'b0, NN - 1);
    send_frame(rand_mat(), 1'b0, NN - 1);
    check_bit("bp_s_ready_low", bus.s_ready, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA5;
    bus.s_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("bp_still_low", bus.s_ready, 1'b0);
    check_int("bp_model_cnt", cnt, 0);
    check_int("bp_model_occ", exp_q.size(), 2);
    bus.s_valid = 1'b0;
    mr_mode = 1;
    send_frame(rand_mat(), 1'b0, NN - 1);
    drain();
    check_int("bp_hs", hs_cnt - h0, 3);

    // Framing error: early s_last at k=5, missing at k=15
    e0 = err_pulses;
    h0 = hs_cnt;
    send_frame(rand_mat(), 1'b0, 5);
    drain();
    check_int("ferr_pulses", err_pulses - e0, 2);
    check_int("ferr_hs", hs_cnt - h0, 1);

    // Random valid/ready
    mr_mode = 2;
    h0 = hs_cnt;
    for (int f = 0; f < 20; f++) send_frame(rand_mat(), 1'b1, NN - 1);
    mr_mode = 1;
    drain();
    check_int("rand_hs", hs_cnt - h0, 20);

    // Reset mid-frame with a matrix pending
    mr_mode = 0;
    @(posedge clk); #1;
    send_frame(rand_mat(), 1'b0, NN - 1);
    m = rand_mat();
    for (int k = 0; k < 7; k++) send(m[k*W +: W], 1'b0, 1'b0);
    check_bit("mr_pending", bus.m_valid, 1'b1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check_bit("mr_rst_m_valid", bus.m_valid, 1'b0);
    check_bit("mr_rst_s_ready", bus.s_ready, 1'b0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check_bit("mr_rel_s_ready", bus.s_ready, 1'b1);
    check_bit("mr_rel_m_valid", bus.m_valid, 1'b0);
    mr_mode = 1;
    h0 = hs_cnt;
    send_frame(rand_mat(), 1'b0, NN - 1);
    drain();
    check_int("mr_hs", hs_cnt - h0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
